axi_sram_slave: RTL
===================

# axi_sram_slave

AXI4 slave-side responder that bridges one slave port of the AXI interconnect (S0/S1 side, 8-bit slave IDs) to a single-port synchronous SRAM macro. It accepts read and write bursts, handles one transaction at a time, and returns R beats and B responses with the extended slave ID echoed unchanged, so the interconnect can route each response to the master that issued the request.

## Interface

Parameters:
- SRAM_ADDR_BITS, 14 — SRAM word-address width (64 KB of 32-bit words).

Ports (one clock; reset is asynchronous and active-low):
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- ARID_S / ARADDR_S / ARLEN_S / ARSIZE_S / ARBURST_S  in  8/32/4/3/2  read address
- ARVALID_S  in  1;  ARREADY_S  out  1
- RID_S  out  8;  RDATA_S  out  32;  RRESP_S  out  2;  RLAST_S  out  1;  RVALID_S  out  1;  RREADY_S  in  1
- AWID_S / AWADDR_S / AWLEN_S / AWSIZE_S / AWBURST_S  in  8/32/4/3/2  write address
- AWVALID_S  in  1;  AWREADY_S  out  1
- WDATA_S  in  32;  WSTRB_S  in  4;  WLAST_S  in  1;  WVALID_S  in  1;  WREADY_S  out  1
- BID_S  out  8;  BRESP_S  out  2;  BVALID_S  out  1;  BREADY_S  in  1
- SRAM_CS  out  1  chip select, active high
- SRAM_OE  out  1  output enable, active high
- SRAM_WEB  out  4  per-byte write enable, active low
- SRAM_A  out  SRAM_ADDR_BITS  word address
- SRAM_DI  out  32  write data
- SRAM_DO  in  32  read data, valid the cycle after the address is sampled

## Operation

- FSM states: IDLE, RADDR, RDATA, WDATA, WRESP. Reset state is IDLE.
- IDLE: AWREADY_S=1; ARREADY_S = ~AWVALID_S, so write wins on a simultaneous request. On AW handshake, latch id/addr/len and go to WDATA. On AR handshake, latch the same fields and go to RADDR.
- RADDR: SRAM_CS=1, SRAM_OE=1, SRAM_WEB=4'hF, SRAM_A=addr_q. Next state is always RDATA.
- RDATA: same SRAM controls. RVALID_S=1, RDATA_S=SRAM_DO, RID_S=id_q, RRESP_S=2'b00, RLAST_S=(cnt_q==len_q).
  - On R handshake with RLAST_S: go to IDLE.
  - On any other R handshake: increment addr_q and cnt_q, go to RADDR.
  - RREADY_S low: hold the state. Address and OE stay stable, so the data stays stable.
- WDATA: WREADY_S=1. On W handshake: SRAM_CS=1, SRAM_OE=0, SRAM_WEB=~WSTRB_S, SRAM_A=addr_q, SRAM_DI=WDATA_S in the same cycle. addr_q then increments. WLAST_S moves the FSM to WRESP; the beat count is not checked against len.
- WRESP: BVALID_S=1, BID_S=id_q, BRESP_S=2'b00. BREADY_S moves the FSM to IDLE.
- Address rules:
  - word address = ADDR[SRAM_ADDR_BITS+1:2]; upper bits are ignored because the interconnect has already decoded the slave.
  - Increment wraps modulo 2^SRAM_ADDR_BITS.
  - SIZE is treated as 3'b010 and BURST as INCR regardless of their value. Responses are always OKAY.
- Outside access cycles: SRAM_CS=0, SRAM_OE=0, SRAM_WEB=4'hF.

## Timing

- Reset values (ARESETn low, FSM in IDLE): ARREADY_S=~AWVALID_S, AWREADY_S=1, RVALID_S=0, RLAST_S=0, RID_S=0, RDATA_S=SRAM_DO, WREADY_S=0, BVALID_S=0, BID_S=0, RRESP_S=BRESP_S=0, SRAM_CS=0, SRAM_OE=0, SRAM_WEB=4'hF, SRAM_A=0, SRAM_DI=0. All internal registers clear.
- Read latency: AR handshake at edge k, RADDR in cycle k+1, RVALID_S high in cycle k+2.
- Read throughput: 2 cycles per beat.
- Write: 1 beat per cycle. BVALID_S is high in the cycle after the WLAST handshake.
- VALID outputs never drop before their handshake completes.
- Reset asserted mid-burst aborts the transaction immediately. No partial response is sent.

## Structure

- Shared package holds:
  - the state enum (IDLE, RADDR, RDATA, WDATA, WRESP)
  - RESP_OKAY=2'b00
  - the SRAM_ADDR_BITS default
- The existing AXI width defines are reused.
- Single module; no sub-module is needed.

## Test plan

- Write: AWADDR=0x10, AWID=0x12, WDATA=0xDEADBEEF, WSTRB=4'hF, WLAST=1 -> SRAM_A=4, SRAM_WEB=4'h0, SRAM_DI=0xDEADBEEF; next cycle BVALID=1, BID=0x12, BRESP=0.
- Read burst: ARADDR=0x10, ARLEN=3, ARID=0x25 -> 4 beats from SRAM words 4,5,6,7; RID=0x25 on every beat; RLAST only on beat 4; first RVALID 2 cycles after the AR handshake.
- Byte strobe: WSTRB=4'b0010 -> SRAM_WEB=4'b1101 for that beat only.
- Simultaneous request: AWVALID and ARVALID in the same cycle -> AW accepted, ARREADY=0 until the B handshake, then the read proceeds.
- Backpressure: RREADY low for 5 cycles mid-burst -> RVALID, RDATA, RLAST and RID stable throughout.
- Wrap and reset:
  - ARADDR=0xFFFC, ARLEN=1 -> SRAM_A=0x3FFF, then 0x0000.
  - ARESETn pulsed during beat 2 -> all outputs at reset values; the next write completes normally.

Source files
------------

// File: rtl/axi_sram_slave_pkg.sv
// Shared types and constants for the AXI-to-SRAM responder.
// Holds the FSM state encoding, the fixed AXI field widths and the response code.
package axi_sram_slave_pkg;

    localparam int AXI_ID_W            = 8;
    localparam int AXI_ADDR_W          = 32;
    localparam int AXI_DATA_W          = 32;
    localparam int AXI_LEN_W           = 4;
    localparam int AXI_STRB_W          = AXI_DATA_W / 8;
    localparam int SRAM_ADDR_BITS_DEF  = 14;

    localparam logic [1:0] RESP_OKAY   = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        RADDR,
        RDATA,
        WDATA,
        WRESP
    } state_t;

endpackage

// File: rtl/axi_sram_slave.sv
// AXI4 slave responder bridging one interconnect slave port to a single-port SRAM.
// One transaction at a time; the extended slave ID is echoed on R and B.
//
// state | meaning
// IDLE  | waiting for AW or AR (write wins a tie)
// RADDR | SRAM address presented for the current read beat
// RDATA | SRAM data returned on R, held until RREADY
// WDATA | accepting W beats, one SRAM write per handshake
// WRESP | B response pending
module axi_sram_slave
    import axi_sram_slave_pkg::*;
#(
    parameter int SRAM_ADDR_BITS = SRAM_ADDR_BITS_DEF
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,

    input  logic [AXI_ID_W-1:0]       ARID_S,
    input  logic [AXI_ADDR_W-1:0]     ARADDR_S,
    input  logic [AXI_LEN_W-1:0]      ARLEN_S,
    input  logic [2:0]                ARSIZE_S,
    input  logic [1:0]                ARBURST_S,
    input  logic                      ARVALID_S,
    output logic                      ARREADY_S,

    output logic [AXI_ID_W-1:0]       RID_S,
    output logic [AXI_DATA_W-1:0]     RDATA_S,
    output logic [1:0]                RRESP_S,
    output logic                      RLAST_S,
    output logic                      RVALID_S,
    input  logic                      RREADY_S,

    input  logic [AXI_ID_W-1:0]       AWID_S,
    input  logic [AXI_ADDR_W-1:0]     AWADDR_S,
    input  logic [AXI_LEN_W-1:0]      AWLEN_S,
    input  logic [2:0]                AWSIZE_S,
    input  logic [1:0]                AWBURST_S,
    input  logic                      AWVALID_S,
    output logic                      AWREADY_S,

    input  logic [AXI_DATA_W-1:0]     WDATA_S,
    input  logic [AXI_STRB_W-1:0]     WSTRB_S,
    input  logic                      WLAST_S,
    input  logic                      WVALID_S,
    output logic                      WREADY_S,

    output logic [AXI_ID_W-1:0]       BID_S,
    output logic [1:0]                BRESP_S,
    output logic                      BVALID_S,
    input  logic                      BREADY_S,

    output logic                      SRAM_CS,
    output logic                      SRAM_OE,
    output logic [AXI_STRB_W-1:0]     SRAM_WEB,
    output logic [SRAM_ADDR_BITS-1:0] SRAM_A,
    output logic [AXI_DATA_W-1:0]     SRAM_DI,
    input  logic [AXI_DATA_W-1:0]     SRAM_DO
);

    state_t                    state_q, state_d;
    logic [AXI_ID_W-1:0]       id_q;
    logic [SRAM_ADDR_BITS-1:0] addr_q;
    logic [AXI_LEN_W-1:0]      len_q;
    logic [AXI_LEN_W-1:0]      cnt_q;

    logic aw_hs, ar_hs, r_hs, w_hs, b_hs;
    logic reading;

    // SIZE/BURST are fixed to word INCR; upper address bits were decoded upstream.
    logic unused_inputs;
    assign unused_inputs = ^{ARSIZE_S, ARBURST_S, AWSIZE_S, AWBURST_S,
                             ARADDR_S[AXI_ADDR_W-1:SRAM_ADDR_BITS+2], ARADDR_S[1:0],
                             AWADDR_S[AXI_ADDR_W-1:SRAM_ADDR_BITS+2], AWADDR_S[1:0]};

    always_comb begin
        AWREADY_S = (state_q == IDLE);
        ARREADY_S = (state_q == IDLE) && !AWVALID_S;
        RVALID_S  = (state_q == RDATA);
        RLAST_S   = (state_q == RDATA) && (cnt_q == len_q);
        WREADY_S  = (state_q == WDATA);
        BVALID_S  = (state_q == WRESP);

        aw_hs     = AWVALID_S && AWREADY_S;
        ar_hs     = ARVALID_S && ARREADY_S;
        r_hs      = RVALID_S && RREADY_S;
        w_hs      = WVALID_S && WREADY_S;
        b_hs      = BVALID_S && BREADY_S;

        RID_S     = id_q;
        RDATA_S   = SRAM_DO;
        RRESP_S   = RESP_OKAY;
        BID_S     = id_q;
        BRESP_S   = RESP_OKAY;

        // Address is held through RDATA so the SRAM keeps re-reading the same word under backpressure.
        reading   = (state_q == RADDR) || (state_q == RDATA);
        SRAM_CS   = reading || w_hs;
        SRAM_OE   = reading;
        SRAM_WEB  = w_hs ? ~WSTRB_S : '1;
        SRAM_A    = addr_q;
        SRAM_DI   = w_hs ? WDATA_S : '0;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (aw_hs)      state_d = WDATA;
                else if (ar_hs) state_d = RADDR;
            end
            RADDR:              state_d = RDATA;
            RDATA: begin
                if (r_hs)       state_d = RLAST_S ? IDLE : RADDR;
            end
            WDATA: begin
                if (w_hs && WLAST_S) state_d = WRESP;
            end
            WRESP: begin
                if (b_hs)       state_d = IDLE;
            end
            default:            state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                if (aw_hs) begin
                    id_q   <= AWID_S;
                    addr_q <= AWADDR_S[SRAM_ADDR_BITS+1:2];
                    len_q  <= AWLEN_S;
                    cnt_q  <= '0;
                end else if (ar_hs) begin
                    id_q   <= ARID_S;
                    addr_q <= ARADDR_S[SRAM_ADDR_BITS+1:2];
                    len_q  <= ARLEN_S;
                    cnt_q  <= '0;
                end
            end
            if (r_hs && !RLAST_S) begin
                addr_q <= addr_q + SRAM_ADDR_BITS'(1);
                cnt_q  <= cnt_q + AXI_LEN_W'(1);
            end
            if (w_hs) begin
                addr_q <= addr_q + SRAM_ADDR_BITS'(1);
            end
        end
    end

endmodule
